square_wave_gen: RTL and testbench



---
 rtl/square_wave_gen.sv | 132 +++++++++++++
 tb/tb_square_wave_gen.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/square_wave_gen.sv
// Programmable square-wave generator: turns a period in clk cycles into a ~50 % duty wave.
// New periods are staged in a pending register and only applied on a period boundary.
module square_wave_gen #(
  parameter int COUNTER_WIDTH = 18,
  parameter int MIN_PERIOD    = 2000,
  parameter int MAX_PERIOD    = 200000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [COUNTER_WIDTH-1:0] period_in,
  input  logic                     period_valid,
  output logic                     period_ready,
  output logic                     wave_out,
  output logic                     edge_pulse,
  output logic                     running,
  output logic [COUNTER_WIDTH-1:0] period_active,
  output logic                     cfg_err,
  output logic [1:0]               dbg_state
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_LOW  = 2'd2;

  localparam logic [COUNTER_WIDTH-1:0] MIN_P = COUNTER_WIDTH'(MIN_PERIOD);
  localparam logic [COUNTER_WIDTH-1:0] MAX_P = COUNTER_WIDTH'(MAX_PERIOD);
  localparam logic [COUNTER_WIDTH-1:0] ONE   = COUNTER_WIDTH'(1);

  logic [1:0]               state_q, state_d;
  logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
  logic [COUNTER_WIDTH-1:0] active_q, active_d;
  logic [COUNTER_WIDTH-1:0] pend_q, pend_d;
  logic                     pend_full_q, pend_full_d;
  logic                     wave_q, edge_q, cfg_err_q;
  logic                     load;
  logic                     accept;
  logic                     in_range;
  logic [COUNTER_WIDTH-1:0] half_len;
  logic [COUNTER_WIDTH-1:0] low_len;

  // Handshake: a transfer happens on a rising edge where period_valid && period_ready;
  // period_ready is high exactly when the pending register is empty.
  assign period_ready = ~pend_full_q;
  assign accept       = period_valid & ~pend_full_q;
  assign in_range     = (period_in >= MIN_P) && (period_in <= MAX_P);

  assign half_len = active_q >> 1;
  assign low_len  = active_q - half_len;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + ONE;
    load     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = ONE;
        if (enable && (pend_full_q || (active_q != '0))) begin
          state_d = ST_HIGH;
          load    = pend_full_q;
        end
      end
      ST_HIGH: begin
        if (cnt_q >= half_len) begin
          state_d = ST_LOW;
          cnt_d   = ONE;
        end
      end
      ST_LOW: begin
        if (cnt_q >= low_len) begin
          cnt_d = ONE;
          if (enable) begin
            state_d = ST_HIGH;
            load    = pend_full_q;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = ONE;
      end
    endcase
  end

  // Load (needs full) and accept (needs empty) are mutually exclusive.
  always_comb begin
    active_d    = active_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    if (load) begin
      active_d    = pend_q;
      pend_full_d = 1'b0;
    end
    if (accept && in_range) begin
      pend_d      = period_in;
      pend_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= ONE;
      active_q    <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      wave_q      <= 1'b0;
      edge_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      active_q    <= active_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      // Registered from the next state so wave_out lines up with running and period_active.
      wave_q      <= (state_d == ST_HIGH);
      edge_q      <= (state_d == ST_HIGH) && (state_q != ST_HIGH);
      cfg_err_q   <= accept & ~in_range;
    end
  end

  assign wave_out      = wave_q;
  assign edge_pulse    = edge_q;
  assign running       = (state_q != ST_IDLE);
  assign period_active = active_q;
  assign cfg_err       = cfg_err_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_square_wave_gen.sv
// Self-checking bench for square_wave_gen: per-cycle expected {wave, edge, running} queue.
module tb_square_wave_gen;

  localparam int CW = 18;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic [CW-1:0] period_in = '0;
  logic          period_valid = 1'b0;
  logic          period_ready;
  logic          wave_out;
  logic          edge_pulse;
  logic          running;
  logic [CW-1:0] period_active;
  logic          cfg_err;
  logic [1:0]    dbg_state;

  logic [2:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  square_wave_gen #(
    .COUNTER_WIDTH(CW),
    .MIN_PERIOD   (2),
    .MAX_PERIOD   (1000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .period_in    (period_in),
    .period_valid (period_valid),
    .period_ready (period_ready),
    .wave_out     (wave_out),
    .edge_pulse   (edge_pulse),
    .running      (running),
    .period_active(period_active),
    .cfg_err      (cfg_err),
    .dbg_state    (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic send(input int p);
    period_in    = CW'(p);
    period_valid = 1'b1;
    tick();
    period_valid = 1'b0;
  endtask

  task automatic push_period(input int p);
    int h;
    logic [2:0] e;
    h = p >> 1;
    for (int i = 0; i < p; i++) begin
      e[2] = (i < h);
      e[1] = (i == 0);
      e[0] = 1'b1;
      exp_q.push_back(e);
    end
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(3'b000);
  endtask

  task automatic drain(input int n);
    logic [2:0] e;
    for (int i = 0; i < n; i++) begin
      if (exp_q.size() == 0) break;
      tick();
      e = exp_q.pop_front();
      chk("wave", 32'(wave_out), 32'(e[2]));
      chk("edge", 32'(edge_pulse), 32'(e[1]));
      chk("running", 32'(running), 32'(e[0]));
    end
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_wave", 32'(wave_out), 0);
    chk("rst_ready", 32'(period_ready), 1);
    chk("rst_running", 32'(running), 0);
    chk("rst_active", 32'(period_active), 0);
    chk("rst_cfg_err", 32'(cfg_err), 0);
    chk("rst_edge", 32'(edge_pulse), 0);
    apply_reset();

    // period 4
    enable = 1'b1;
    send(4);
    chk("p4_ready_pend", 32'(period_ready), 0);
    chk("p4_wave_t1", 32'(wave_out), 0);
    chk("p4_running_t1", 32'(running), 0);
    push_period(4); push_period(4); push_period(4);
    drain(1);
    chk("p4_active", 32'(period_active), 4);
    chk("p4_ready_load", 32'(period_ready), 1);
    drain(11);

    // period 5, odd extra cycle in LOW
    apply_reset();
    send(5);
    push_period(5); push_period(5); push_period(5);
    drain(15);
    chk("p5_active", 32'(period_active), 5);

    // out-of-range offers
    apply_reset();
    period_in = CW'(1); period_valid = 1'b1;
    tick();
    period_valid = 1'b0;
    chk("err1_cfg", 32'(cfg_err), 1);
    chk("err1_ready", 32'(period_ready), 1);
    tick();
    chk("err1_clear", 32'(cfg_err), 0);
    period_in = CW'(1001); period_valid = 1'b1;
    tick();
    period_valid = 1'b0;
    chk("err1001_cfg", 32'(cfg_err), 1);
    chk("err1001_ready", 32'(period_ready), 1);
    tick();
    chk("err1001_clear", 32'(cfg_err), 0);
    push_idle(6);
    drain(6);
    chk("err_active", 32'(period_active), 0);

    // period change 8 -> 6 offered during HIGH
    apply_reset();
    send(8);
    push_period(8); push_period(6); push_period(6);
    drain(1);
    period_in = CW'(6); period_valid = 1'b1;
    drain(1);
    chk("chg_ready_acc", 32'(period_ready), 0);
    period_in = CW'(9);
    drain(2);
    chk("chg_ready_hold", 32'(period_ready), 0);
    period_valid = 1'b0;
    drain(4);
    chk("chg_ready_low", 32'(period_ready), 0);
    chk("chg_active_old", 32'(period_active), 8);
    drain(1);
    chk("chg_active_new", 32'(period_active), 6);
    chk("chg_ready_new", 32'(period_ready), 1);
    drain(11);
    chk("chg_active_kept", 32'(period_active), 6);

    // enable dropped mid-period, then restart without a transfer
    apply_reset();
    send(10);
    push_period(10);
    drain(2);
    enable = 1'b0;
    drain(8);
    push_idle(4);
    drain(4);
    chk("dis_running", 32'(running), 0);
    chk("dis_active", 32'(period_active), 10);
    enable = 1'b1;
    push_period(10); push_period(10);
    drain(20);

    // asynchronous reset mid-HIGH with pending full
    apply_reset();
    send(8);
    push_period(8);
    drain(2);
    period_in = CW'(6); period_valid = 1'b1;
    drain(1);
    period_valid = 1'b0;
    chk("ar_pend_full", 32'(period_ready), 0);
    rst = 1'b1;
    #1;
    chk("ar_wave", 32'(wave_out), 0);
    chk("ar_running", 32'(running), 0);
    chk("ar_active", 32'(period_active), 0);
    chk("ar_ready", 32'(period_ready), 1);
    tick();
    rst = 1'b0;
    exp_q.delete();
    push_idle(12);
    drain(12);
    chk("ar_active_after", 32'(period_active), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
